axi_stream_strip_header: RTL



---
 rtl/axi_stream_strip_header.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axi_stream_strip_header.sv
// Strips a 1..DATA_BYTE_WD byte header from the front of each AXI Stream packet,
// emits it on a side channel and re-packs the remaining payload into full beats.
module axi_stream_strip_header #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr,
  output logic                    err_short
);

  localparam int unsigned CNT_WD = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [CNT_WD-1:0]       s_q, s_d;
  logic [CNT_WD-1:0]       resid_cnt_q, resid_cnt_d;
  logic [DATA_WD-1:0]      resid_q, resid_d;

  logic                    valid_out_d, last_out_d;
  logic [DATA_WD-1:0]      data_out_d;
  logic [DATA_BYTE_WD-1:0] keep_out_d;
  logic                    valid_hdr_d;
  logic [DATA_WD-1:0]      data_hdr_d;
  logic [DATA_BYTE_WD-1:0] keep_hdr_d;
  logic                    err_short_d;
  logic                    ready_strip_d;

  logic                    in_hs;
  logic [CNT_WD-1:0]       k_in;
  logic [DATA_WD-1:0]      data_m;
  logic [DATA_WD-1:0]      resid_new;
  logic [DATA_WD-1:0]      data_low;
  logic [31:0]             hi_sh, lo_sh;

  // Mask with the top n byte lanes set; n may equal DATA_BYTE_WD.
  function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [CNT_WD-1:0] n);
    return ~({DATA_BYTE_WD{1'b1}} >> n);
  endfunction

  function automatic logic [DATA_WD-1:0] expand(input logic [DATA_BYTE_WD-1:0] m);
    logic [DATA_WD-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic logic [CNT_WD-1:0] popcount(input logic [DATA_BYTE_WD-1:0] m);
    logic [CNT_WD-1:0] c;
    c = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) c = c + CNT_WD'(m[i]);
    return c;
  endfunction

  // Byte-lane alignment helpers: header occupies the top S lanes of the first beat.
  assign data_m    = data_in & expand(keep_in);
  assign k_in      = popcount(keep_in);
  assign hi_sh     = (DATA_BYTE_WD - 32'(s_q)) * 8;
  assign lo_sh     = 32'(s_q) * 8;
  assign data_low  = data_m >> hi_sh;
  assign resid_new = data_m << lo_sh;

  always_comb begin
    unique case (state_q)
      HDR:     ready_in = ~valid_hdr | ready_hdr;
      BODY:    ready_in = ~valid_out | ready_out;
      default: ready_in = 1'b0;
    endcase
  end

  assign in_hs = valid_in & ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and next-register values.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    resid_d     = resid_q;
    resid_cnt_d = resid_cnt_q;
    valid_out_d = valid_out & ~ready_out;
    data_out_d  = data_out;
    keep_out_d  = keep_out;
    last_out_d  = last_out;
    valid_hdr_d = valid_hdr & ~ready_hdr;
    data_hdr_d  = data_hdr;
    keep_hdr_d  = keep_hdr;
    err_short_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_strip) begin
          s_d     = CNT_WD'(byte_strip_cnt) + CNT_WD'(1);
          state_d = HDR;
        end
      end
      HDR: begin
        if (in_hs) begin
          valid_hdr_d = 1'b1;
          data_hdr_d  = data_m & expand(top_mask(s_q));
          keep_hdr_d  = top_mask(s_q) & keep_in;
          resid_d     = resid_new;
          resid_cnt_d = (k_in > s_q) ? k_in - s_q : '0;
          err_short_d = (k_in < s_q);
          if (!last_in)         state_d = BODY;
          else if (k_in > s_q)  state_d = FLUSH;
          else                  state_d = IDLE;
        end
      end
      BODY: begin
        if (in_hs) begin
          valid_out_d = 1'b1;
          data_out_d  = resid_q | data_low;
          resid_d     = resid_new;
          keep_out_d  = '1;
          last_out_d  = 1'b0;
          if (last_in) begin
            if (k_in <= s_q) begin
              keep_out_d = top_mask(CNT_WD'(DATA_BYTE_WD) - s_q + k_in);
              last_out_d = 1'b1;
              state_d    = IDLE;
            end else begin
              resid_cnt_d = k_in - s_q;
              state_d     = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (!valid_out || ready_out) begin
          valid_out_d = 1'b1;
          data_out_d  = resid_q;
          keep_out_d  = top_mask(resid_cnt_q);
          last_out_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_strip_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= CNT_WD'(1);
      resid_q     <= '0;
      resid_cnt_q <= '0;
      valid_out   <= 1'b0;
      data_out    <= '0;
      keep_out    <= '0;
      last_out    <= 1'b0;
      valid_hdr   <= 1'b0;
      data_hdr    <= '0;
      keep_hdr    <= '0;
      err_short   <= 1'b0;
      ready_strip <= 1'b1;
    end else begin
      s_q         <= s_d;
      resid_q     <= resid_d;
      resid_cnt_q <= resid_cnt_d;
      valid_out   <= valid_out_d;
      data_out    <= data_out_d;
      keep_out    <= keep_out_d;
      last_out    <= last_out_d;
      valid_hdr   <= valid_hdr_d;
      data_hdr    <= data_hdr_d;
      keep_hdr    <= keep_hdr_d;
      err_short   <= err_short_d;
      ready_strip <= ready_strip_d;
    end
  end

endmodule
